// File: rtl/down_counter.sv
// Loadable down counter with terminal-count pulse and a clamped load value.
// Optional auto-reload on expiry when DOWN_COUNTER_RELOAD_EN is defined.
module down_counter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned MAX   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state;
    logic [WIDTH-1:0] load_clamped;

`ifdef DOWN_COUNTER_RELOAD_EN
    logic [WIDTH-1:0] reload;
`endif

    always_comb begin
        load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            out   <= '0;
            zero  <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef DOWN_COUNTER_RELOAD_EN
            reload <= '0;
`endif
        end else begin
            done <= 1'b0;
            // Load wins over both decrement and expiry; an aborted count never pulses done.
            if (load) begin
                out <= load_clamped;
`ifdef DOWN_COUNTER_RELOAD_EN
                reload <= load_clamped;
`endif
                if (load_clamped != '0) begin
                    state <= StRun;
                    busy  <= 1'b1;
                    zero  <= 1'b0;
                end else begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    zero  <= 1'b1;
                end
            end else if (state == StRun && en) begin
                if (out == ONE) begin
                    done <= 1'b1;
`ifdef DOWN_COUNTER_RELOAD_EN
                    out <= reload;
`else
                    out   <= '0;
                    state <= StIdle;
                    busy  <= 1'b0;
                    zero  <= 1'b1;
`endif
                end else begin
                    out <= out - ONE;
                end
            end
        end
    end

endmodule
